// File: rtl/dl_ram_arbiter_pkg.sv
// dl_arb_pkg: shared definitions for the download/CPU RAM arbiter.
//   arb_state_t    - arbiter FSM encoding (IDLE=0, DL_WR=1, CPU_ACC=2, HOLD=3)
//   DATA_W         - download / CPU data width
//   fifo_entry_w() - width of one download FIFO entry {addr, data}
package dl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DL_WR   = 2'd1,
        CPU_ACC = 2'd2,
        HOLD    = 2'd3
    } arb_state_t;

    localparam int DATA_W = 8;

    function automatic int fifo_entry_w(input int aw);
        return aw + DATA_W;
    endfunction

endpackage

// File: rtl/dl_ram_arbiter_if.sv
// dl_ram_arbiter_if: RAM port between the arbiter (master) and the
// SDRAM/SRAM controller (slave).
//   mem_req   master->slave  request, held high until mem_ack
//   mem_we    master->slave  write enable
//   mem_addr  master->slave  address (AW bits)
//   mem_wdata master->slave  write data
//   mem_rdata slave->master  read data, valid with mem_ack
//   mem_ack   slave->master  one-cycle completion pulse
//
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata stable
// and holds all of them until it samples mem_ack=1 at a clock edge; mem_req
// drops at that same edge. mem_ack is a single-cycle pulse and is only
// meaningful while mem_req is high. The master may abandon a request only
// through reset.
interface dl_ram_arbiter_if #(
    parameter int AW = 25
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dl_byte_fifo.sv
// dl_byte_fifo: synchronous show-ahead FIFO for download entries.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write an entry; ignored when full
//   pop        : remove the head entry; ignored when empty
//   rdata      : current head entry (valid while !empty)
//   full/empty : status
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate count.
module dl_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PW-2:0]] <= wdata;
    end

endmodule

// File: rtl/dl_ram_arbiter.sv
// dl_ram_arbiter: shares one external RAM port between the CPU and the
// SPI download write stream. Download bytes are queued in a small FIFO and
// written with absolute priority; the CPU is held in reset during a download
// and for RST_HOLD cycles after the FIFO drains.
//   clk, reset       : clock, asynchronous active-high reset
//   dl_downloading   : download active (level)
//   dl_wr            : one-cycle strobe, dl_addr/dl_data valid
//   dl_addr, dl_data : download byte and its target address
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack : CPU read data and one-cycle completion pulse
//   cpu_reset        : CPU reset hold
//   ram              : RAM port (master side)
//   dl_overflow      : sticky, a download byte was dropped on a full FIFO
//   state_dbg        : current arbiter state
module dl_ram_arbiter
    import dl_arb_pkg::*;
#(
    parameter int AW         = 25,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_HOLD   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_downloading,
    input  logic              dl_wr,
    input  logic [AW-1:0]     dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_reset,
    dl_ram_arbiter_if.master  ram,
    output logic              dl_overflow,
    output arb_state_t        state_dbg
);

    localparam int EW = fifo_entry_w(AW);
    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD - 1);

    // Download FIFO
    logic [EW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    dl_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dl_wr),
        .wdata ({dl_addr, dl_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM and datapath registers
    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rst_hold_q, rst_hold_d;
    logic          dl_active_q;

    // Anything that means download work is pending or arriving.
    logic dl_pending;
    assign dl_pending = dl_downloading || dl_wr || !fifo_empty;

    assign cpu_reset     = rst_hold_q || dl_downloading;
    assign cpu_ack       = cpu_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign ram.mem_req   = mem_req_q;
    assign ram.mem_we    = mem_we_q;
    assign ram.mem_addr  = mem_addr_q;
    assign ram.mem_wdata = mem_wdata_q;
    assign state_dbg     = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            hold_cnt_q  <= '0;
            rst_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_hold_q  <= rst_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hold_cnt_d  = hold_cnt_q;
        // Any cycle of an active download re-arms the CPU reset hold.
        rst_hold_d  = rst_hold_q || dl_downloading;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fifo_rdata[EW-1:DATA_W];
                    mem_wdata_d = fifo_rdata[DATA_W-1:0];
                    state_d     = DL_WR;
                end else if (cpu_req && !cpu_reset && !cpu_ack_q) begin
                    // cpu_ack_q blocks a re-grant while the CPU is still
                    // seeing the completion of its previous request.
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    state_d     = CPU_ACC;
                end else if (rst_hold_q && !dl_pending) begin
                    // Covers both the post-reset hold and a download that
                    // ended while the arbiter was idle.
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end

            DL_WR: begin
                if (ram.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (dl_pending) begin
                        state_d = IDLE;
                    end else begin
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = HOLD;
                    end
                end
            end

            CPU_ACC: begin
                if (ram.mem_ack) begin
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = ram.mem_rdata;
                    cpu_ack_d   = 1'b1;
                    state_d     = IDLE;
                end
            end

            HOLD: begin
                if (dl_pending) begin
                    // New download activity: abandon the countdown and keep
                    // the CPU in reset; IDLE restarts the hold later.
                    state_d = IDLE;
                end else if (hold_cnt_q == '0) begin
                    rst_hold_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow flag; a drop in the same cycle as a new download start
    // belongs to that new download, so setting wins over clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_overflow <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            dl_active_q <= dl_downloading;
            if (dl_wr && fifo_full)
                dl_overflow <= 1'b1;
            else if (dl_downloading && !dl_active_q)
                dl_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dl_ram_arbiter.sv
// tb_dl_ram_arbiter: self-checking bench for dl_ram_arbiter.
// A RAM controller model acknowledges requests with a configurable delay and
// checks each access against a scoreboard queue of expected {we, addr, data}.
module tb_dl_ram_arbiter;
    import dl_arb_pkg::*;

    localparam int AW         = 25;
    localparam int FIFO_DEPTH = 4;
    localparam int RST_HOLD   = 16;
    localparam int SBW        = 1 + AW + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          dl_downloading;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          cpu_reset;
    logic          dl_overflow;
    arb_state_t    state_dbg;

    dl_ram_arbiter_if #(.AW(AW)) ram_if ();

    dl_ram_arbiter #(
        .AW         (AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dl_downloading (dl_downloading),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .cpu_reset      (cpu_reset),
        .ram            (ram_if),
        .dl_overflow    (dl_overflow),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [SBW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cpu_ack_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (cpu_ack) cpu_ack_cnt++;

    // ---------------- RAM controller model ----------------
    int         ack_delay = 0;
    logic       ack_stall = 1'b0;
    logic [7:0] ram_rdata_val = 8'h00;

    initial begin : ram_model
        logic [SBW-1:0] obs;
        logic [SBW-1:0] expv;
        int ack_wait;
        ack_wait = 0;
        ram_if.mem_ack   = 1'b0;
        ram_if.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            ram_if.mem_ack = 1'b0;
            if (reset || !ram_if.mem_req || ack_stall) begin
                ack_wait = 0;
            end else if (ack_wait < ack_delay) begin
                ack_wait++;
            end else begin
                ack_wait = 0;
                obs = {ram_if.mem_we, ram_if.mem_addr, ram_if.mem_wdata};
                check("ram_exp_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    check("ram_access", obs, expv);
                end
                ram_if.mem_rdata = ram_rdata_val;
                ram_if.mem_ack   = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n consecutive dl_wr pulses; only the first n_exp are expected to land.
    task automatic dl_burst(input int n, input logic [AW-1:0] base, input logic [7:0] d0,
                            input int n_exp);
        for (int i = 0; i < n; i++) begin
            dl_wr   = 1'b1;
            dl_addr = base + AW'(i);
            dl_data = d0 + 8'(i);
            if (i < n_exp) exp_q.push_back({1'b1, dl_addr, dl_data});
            @(negedge clk);
        end
        dl_wr = 1'b0;
    endtask

    task automatic cpu_start(input logic [AW-1:0] addr);
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = addr;
        cpu_wdata = 8'h00;
        exp_q.push_back({1'b0, addr, 8'h00});
    endtask

    task automatic cpu_finish(input string tag, input logic [7:0] exp_data);
        for (int i = 0; i < 40 && !cpu_ack; i++) @(negedge clk);
        check({tag, "_ack"}, cpu_ack, 1);
        check({tag, "_rdata"}, cpu_rdata, exp_data);
        cpu_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_1cyc"}, cpu_ack, 0);
    endtask

    task automatic wait_state(input arb_state_t s, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && state_dbg != s; i++) @(negedge clk);
        check(tag, state_dbg, s);
    endtask

    // Called on the first negedge in HOLD; counts cycles until release.
    task automatic measure_hold(input string tag);
        int n;
        n = 0;
        while (cpu_reset && n < 4 * RST_HOLD) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, RST_HOLD);
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || state_dbg != IDLE); i++)
            @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int ack_snap;
        int busy;
        reset = 1'b1;
        dl_downloading = 1'b0;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = 8'h00;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = 8'h00;

        // Reset values
        tick(3);
        check("rst_mem_req", ram_if.mem_req, 0);
        check("rst_mem_we", ram_if.mem_we, 0);
        check("rst_mem_addr", ram_if.mem_addr, 0);
        check("rst_mem_wdata", ram_if.mem_wdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_overflow", dl_overflow, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_state", state_dbg, IDLE);

        // Test 1: post-reset hold, then a CPU read
        reset = 1'b0;
        wait_state(HOLD, 5, "t1_hold_entry");
        measure_hold("t1_hold_len");
        ram_rdata_val = 8'h5A;
        ack_delay = 1;
        cpu_start(25'h000100);
        cpu_finish("t1_rd", 8'h5A);

        // Test 2: 3-byte download, RAM ack delayed 3 cycles
        ack_delay = 3;
        dl_downloading = 1'b1;
        tick(1);
        check("t2_cpu_reset", cpu_reset, 1);
        dl_burst(1, 25'h10000, 8'hA1, 1);
        check("t2_lat_n", ram_if.mem_req, 0);
        tick(1);
        check("t2_lat_n1", ram_if.mem_req, 1);
        dl_burst(2, 25'h10001, 8'hA2, 2);
        dl_downloading = 1'b0;
        tick(1);
        check("t2_reset_after_fall", cpu_reset, 1);
        wait_state(HOLD, 60, "t2_hold_entry");
        check("t2_all_written", exp_q.size(), 0);
        measure_hold("t2_hold_len");

        // Test 4: CPU access in flight when a download starts
        ack_stall = 1'b1;
        ack_delay = 1;
        ram_rdata_val = 8'h77;
        cpu_start(25'h000200);
        wait_state(CPU_ACC, 10, "t4_grant");
        dl_downloading = 1'b1;
        dl_burst(1, 25'h10010, 8'hC3, 1);
        check("t4_cpu_reset", cpu_reset, 1);
        ack_stall = 1'b0;
        cpu_finish("t4_rd", 8'h77);
        wait_drained("t4_dl_written");
        cpu_start(25'h000300);
        ack_snap = cpu_ack_cnt;
        // Held request must not be granted while the download is active.
        void'(exp_q.pop_back());
        tick(5);
        dl_downloading = 1'b0;
        for (int i = 0; i < 60 && cpu_reset; i++) @(negedge clk);
        check("t4_released", cpu_reset, 0);
        check("t4_no_ack_held", cpu_ack_cnt, ack_snap);
        exp_q.push_back({1'b0, 25'h000300, 8'h00});
        ram_rdata_val = 8'h3C;
        cpu_finish("t4_rd2", 8'h3C);

        // Test 3: overflow with RAM stalled
        ack_delay = 0;
        ack_stall = 1'b1;
        dl_downloading = 1'b1;
        tick(1);
        // Byte 1 moves into the RAM registers, bytes 2-5 fill the FIFO, 6 drops.
        dl_burst(6, 25'h12000, 8'h30, 5);
        check("t3_overflow_set", dl_overflow, 1);
        ack_stall = 1'b0;
        wait_drained("t3_drained");
        dl_downloading = 1'b0;
        tick(2);
        check("t3_overflow_sticky", dl_overflow, 1);
        dl_downloading = 1'b1;
        tick(1);
        check("t3_overflow_clear", dl_overflow, 0);

        // Test 5: download re-asserted during HOLD at count 5
        tick(2);
        dl_downloading = 1'b0;
        wait_state(HOLD, 10, "t5_hold_entry");
        tick(10);
        dl_downloading = 1'b1;
        tick(4);
        check("t5_reset_held", cpu_reset, 1);
        check("t5_hold_abort", state_dbg, IDLE);
        dl_downloading = 1'b0;
        wait_state(HOLD, 10, "t5_hold_reentry");
        measure_hold("t5_hold_restart");

        // Test 6: reset mid-write
        ack_stall = 1'b1;
        dl_downloading = 1'b1;
        dl_burst(6, 25'h1F000, 8'h90, 5);
        wait_state(DL_WR, 10, "t6_in_dl_wr");
        check("t6_overflow_pre", dl_overflow, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_mem_req", ram_if.mem_req, 0);
        check("t6_mem_we", ram_if.mem_we, 0);
        check("t6_mem_addr", ram_if.mem_addr, 0);
        check("t6_mem_wdata", ram_if.mem_wdata, 0);
        check("t6_cpu_rdata", cpu_rdata, 0);
        check("t6_overflow", dl_overflow, 0);
        check("t6_state", state_dbg, IDLE);
        exp_q.delete();
        dl_downloading = 1'b0;
        ack_stall = 1'b0;
        @(negedge clk);
        check("t6_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ram_if.mem_req) busy++;
        end
        check("t6_fifo_empty", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
